// File: rtl/hazard_mem_unit_if.sv
// Bundle of datapath taps and hazard controls between the 5-stage pipeline and hazard_mem_unit.
// The counter ports exist only when HZ_PERF_CNT_EN is defined.
interface hazard_mem_unit_if #(
  parameter int REGW = 5
`ifdef HZ_PERF_CNT_EN
  , parameter int CNTW = 32
`endif
);
  logic            en;
  logic [REGW-1:0] Rs1D, Rs2D;
  logic [REGW-1:0] Rs1E, Rs2E, RdE;
  logic            ResultSrcEb0;
  logic            PCSrcE;
  logic [REGW-1:0] RdM;
  logic            RegWriteM;
  logic            MemReqM;
  logic            mem_ack;
  logic [REGW-1:0] RdW;
  logic            RegWriteW;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, StallE, StallM;
  logic            FlushD, FlushE, FlushW;
  logic            MemErr;
`ifdef HZ_PERF_CNT_EN
  logic [CNTW-1:0] StallCnt, FlushCnt;
`endif

  // Datapath side: drives the taps, consumes the controls.
  modport master (
`ifdef HZ_PERF_CNT_EN
    input  StallCnt, FlushCnt,
`endif
    output en, Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcEb0, PCSrcE,
           RdM, RegWriteM, MemReqM, mem_ack, RdW, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr
  );

  modport slave (
`ifdef HZ_PERF_CNT_EN
    output StallCnt, FlushCnt,
`endif
    input  en, Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcEb0, PCSrcE,
           RdM, RegWriteM, MemReqM, mem_ack, RdW, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr
  );
endinterface

// File: rtl/hazard_mem_unit.sv
// Hazard controller: forwarding, load-use stall, branch flush, variable-latency memory freeze
// with timeout error. Optional stall/flush performance counters under HZ_PERF_CNT_EN.
module hazard_mem_unit #(
  parameter int REGW    = 5,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 32
) (
  input logic               clk,
  input logic               rst,
  hazard_mem_unit_if.slave  hz
);

  if (TIMEOUT < 2 || TIMEOUT > 255 || CNTW < 1) begin : g_param_check
    $error("hazard_mem_unit: TIMEOUT must be 2..255 and CNTW at least 1");
  end

  localparam logic [REGW-1:0] ZERO_REG   = '0;
  localparam logic [7:0]      TIMEOUT_W  = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t     state;
  logic [7:0] wcnt;
  logic       mem_err;
  logic       lw_stall;
  logic       mem_stall;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;

  // The memory stage has priority over writeback since it holds the younger result.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && hz.RdM != ZERO_REG && hz.RdM == hz.Rs1E)
      fwd_a = 2'b10;
    else if (hz.RegWriteW && hz.RdW != ZERO_REG && hz.RdW == hz.Rs1E)
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (hz.RegWriteM && hz.RdM != ZERO_REG && hz.RdM == hz.Rs2E)
      fwd_b = 2'b10;
    else if (hz.RegWriteW && hz.RdW != ZERO_REG && hz.RdW == hz.Rs2E)
      fwd_b = 2'b01;
  end

  assign lw_stall  = hz.ResultSrcEb0 && hz.RdE != ZERO_REG &&
                     (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
  assign mem_stall = (hz.MemReqM && !hz.mem_ack) || (state == ERR);

  // A memory freeze holds E, so a branch resolving there must not squash anything yet.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wcnt    <= 8'd0;
      mem_err <= 1'b0;
    end else if (hz.en) begin
      case (state)
        IDLE: begin
          if (hz.MemReqM && !hz.mem_ack) begin
            state <= WAIT;
            wcnt  <= 8'd1;
          end
        end
        WAIT: begin
          if (hz.mem_ack || !hz.MemReqM) begin
            state <= IDLE;
            wcnt  <= 8'd0;
          end else begin
            wcnt <= wcnt + 8'd1;
            if (wcnt + 8'd1 == TIMEOUT_W) begin
              state   <= ERR;
              mem_err <= 1'b1;
            end
          end
        end
        ERR:     mem_err <= 1'b1;
        default: state   <= IDLE;
      endcase
    end
  end

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.MemErr    = mem_err;

`ifdef HZ_PERF_CNT_EN
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  // Both counters saturate rather than wrap so a long run never reads as a short one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.en) begin
      if ((stall_f || stall_d || stall_e || stall_m) && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if ((flush_d || flush_e) && !(&flush_cnt))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.StallCnt = stall_cnt;
  assign hz.FlushCnt = flush_cnt;
`endif

endmodule

// File: doc/hazard_mem_unit.md
# hazard_mem_unit

- Parametrised hazard controller for the 5-stage in-order pipeline.
- Generates forwarding selects, load-use stalls and branch flushes.
- Adds what the fixed-latency pipeline lacks: a handshake with variable-latency data memory, a full-pipe freeze while a memory access waits, a timeout error state, and optional stall/flush performance counters.
- Sits beside the datapath; consumes its stage register-index/control taps and drives its stall/flush/forward inputs.

## Interface
Parameters:
- REGW, 5, register index width (register file has 2**REGW entries).
- TIMEOUT, 16, max consecutive unacknowledged memory-request cycles before error; legal range 2..255.
- CNTW, 32, performance counter width (used only with HZ_PERF_CNT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  global enable; when low, FSM and counters hold.
- Rs1D, Rs2D  in  REGW  decode-stage source registers.
- Rs1E, Rs2E, RdE  in  REGW  execute-stage sources/destination.
- ResultSrcEb0  in  1  execute-stage instruction is a load.
- PCSrcE  in  1  taken branch/jump in execute.
- RdM  in  REGW, RegWriteM  in  1  memory-stage destination/write enable.
- MemReqM  in  1  memory stage holds a load or store.
- mem_ack  in  1  data memory completes the current request this cycle.
- RdW  in  REGW, RegWriteW  in  1  writeback-stage destination/write enable.
- ForwardAE, ForwardBE  out  2  ALU operand selects: 00 register file, 01 ResultW, 10 ALUResultM.
- StallF, StallD, StallE, StallM  out  1  hold the PC/fetch/decode/execute pipe registers.
- FlushD, FlushE, FlushW  out  1  clear the fetch/decode/mem pipe registers.
- MemErr  out  1  sticky memory timeout error.
- StallCnt, FlushCnt  out  CNTW  performance counters (present only with HZ_PERF_CNT_EN).

## Operation
- Forward A: 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. M has priority over W. Forward B is identical using Rs2E.
- lwStall = ResultSrcEb0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = (MemReqM & ~mem_ack) | (state==ERR).
- Priority, highest first:
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; PCSrcE is ignored because E is held.
  - PCSrcE: FlushD=FlushE=1, all stalls 0. Wins over lwStall because the dependent D instruction is squashed.
  - lwStall: StallF=StallD=1, FlushE=1.
  - otherwise: all stall and flush outputs 0.
- FSM states: IDLE, WAIT, ERR. Unacked-cycle counter wcnt, width 8.
  - IDLE: on MemReqM & ~mem_ack go to WAIT with wcnt=1.
  - WAIT, mem_ack or ~MemReqM: go to IDLE, wcnt=0.
  - WAIT, otherwise: wcnt+1; go to ERR when wcnt+1==TIMEOUT.
  - ERR: absorbing; MemErr=1 and the pipe stays frozen until rst.
- FSM updates only when en=1. Combinational outputs are valid regardless of en.

## Timing
- Forward, stall and flush outputs are combinational from inputs and state: zero latency in the same cycle.
- Single-cycle ack (mem_ack high in the first request cycle): no stall and no FSM transition.
- N-cycle memory: memStall is high for exactly N-1 cycles; the release occurs in the ack cycle.
- ERR is entered on the clock edge ending the TIMEOUT-th consecutive unacked cycle. MemErr rises in the following cycle.
- Reset, including mid-WAIT: asynchronously state=IDLE, wcnt=0, MemErr=0, counters=0.
- Output values with inputs idle: all outputs 0.

## Configuration
- HZ_PERF_CNT_EN defined:
  - StallCnt increments each en cycle with any of StallF/StallD/StallE/StallM high.
  - FlushCnt increments each en cycle with FlushD or FlushE high.
  - Both counters saturate at all-ones and reset asynchronously to 0.
- HZ_PERF_CNT_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set Rs1E=0 with RdM=RdW=0 -> ForwardAE=00.
- Load-use: ResultSrcEb0=1, RdE=3, Rs2D=3 -> StallF=StallD=FlushE=1 for one cycle. Repeat with RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 together with lwStall conditions -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, mem_ack low for 3 cycles then high -> StallF/D/E/M and FlushW high for exactly 3 cycles, FSM back in IDLE. Assert PCSrcE during the wait -> no flush.
- Timeout: TIMEOUT=4, MemReqM=1 with mem_ack never asserted -> MemErr=1 from cycle 5 and stays high. Pulse rst -> MemErr=0, state IDLE.
- Counters (HZ_PERF_CNT_EN, CNTW=2): 5 stall cycles -> StallCnt=3 (saturated). Drop en during a stall -> counter holds.
